pdp_exec_mem_responder: RTL and testbench

//  Memory-side responder for the EXEC unit's read/write memory interface, plus the instruction-fetch read port.

---
 rtl/pdp_exec_mem_responder.sv | 121 ++++++++++++
 tb/tb_pdp_exec_mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pdp_exec_mem_responder.sv
// rtl/pdp_exec_mem_responder.sv - PDP-8 main store with EXEC read/write port, fetch read port and request stats
module pdp_exec_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MEM_DEPTH  = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  input  logic                  init_wr_en,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic [CNT_WIDTH-1:0]  exec_rd_cnt,
  output logic [CNT_WIDTH-1:0]  exec_wr_cnt,
  output logic [CNT_WIDTH-1:0]  ifu_rd_cnt,
  output logic                  proto_err
);

  // Addresses wrap modulo the array size; upper address bits are simply dropped.
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] r_ifu_rd_data;
  logic [DATA_WIDTH-1:0] r_exec_rd_data;
  logic [CNT_WIDTH-1:0]  r_exec_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_exec_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_ifu_rd_cnt;
  logic                  r_proto_err;
  logic [1:0]            r_rd_run;

  logic [MEM_AW-1:0]     w_ifu_a;
  logic [MEM_AW-1:0]     w_exec_rd_a;
  logic [MEM_AW-1:0]     w_wr_a;
  logic [DATA_WIDTH-1:0] w_wr_d;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_ifu_rdata;
  logic [DATA_WIDTH-1:0] w_exec_rdata;
  logic                  w_exec_wr_commit;
  logic                  w_err_event;
  logic [1:0]            w_rd_run_nxt;

  assign w_ifu_a     = ifu_rd_addr[MEM_AW-1:0];
  assign w_exec_rd_a = exec_rd_addr[MEM_AW-1:0];

  // Single write port: the preload strobe has priority over an EXEC write.
  assign w_wr_en          = init_wr_en | exec_wr_req;
  assign w_wr_a           = init_wr_en ? init_addr[MEM_AW-1:0] : exec_wr_addr[MEM_AW-1:0];
  assign w_wr_d           = init_wr_en ? init_data : exec_wr_data;
  assign w_exec_wr_commit = exec_wr_req & ~init_wr_en;

  // Write-first bypass so a read colliding with this edge's write sees the new word.
  assign w_ifu_rdata  = (w_wr_en && (w_wr_a == w_ifu_a)) ? w_wr_d : r_mem[w_ifu_a];
  assign w_exec_rdata = (w_wr_en && (w_wr_a == w_exec_rd_a)) ? w_wr_d : r_mem[w_exec_rd_a];

  // Consecutive-read run length; saturates so a long burst never wraps back to "short".
  assign w_rd_run_nxt = !exec_rd_req      ? 2'd0 :
                        (r_rd_run == 2'd3) ? 2'd3 : r_rd_run + 2'd1;

  // Any protocol misuse this cycle: dropped EXEC write, read+write together, or a third back-to-back read.
  assign w_err_event = (init_wr_en & exec_wr_req) |
                       (exec_rd_req & exec_wr_req) |
                       (exec_rd_req & (r_rd_run >= 2'd2));

  // Array write; the store is deliberately not cleared by reset, but writes are blocked on a reset edge.
  always_ff @(posedge clk) begin
    if (reset_n && w_wr_en) begin
      r_mem[w_wr_a] <= w_wr_d;
    end
  end

  // Read data registers, request counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ifu_rd_data  <= '0;
      r_exec_rd_data <= '0;
      r_exec_rd_cnt  <= '0;
      r_exec_wr_cnt  <= '0;
      r_ifu_rd_cnt   <= '0;
      r_proto_err    <= 1'b0;
      r_rd_run       <= 2'd0;
    end else begin
      r_rd_run <= w_rd_run_nxt;
      if (w_err_event) begin
        r_proto_err <= 1'b1;
      end
      if (ifu_rd_req) begin
        r_ifu_rd_data <= w_ifu_rdata;
        if (r_ifu_rd_cnt != '1) begin
          r_ifu_rd_cnt <= r_ifu_rd_cnt + CNT_WIDTH'(1);
        end
      end
      if (exec_rd_req) begin
        r_exec_rd_data <= w_exec_rdata;
        if (r_exec_rd_cnt != '1) begin
          r_exec_rd_cnt <= r_exec_rd_cnt + CNT_WIDTH'(1);
        end
      end
      if (w_exec_wr_commit && (r_exec_wr_cnt != '1)) begin
        r_exec_wr_cnt <= r_exec_wr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign ifu_rd_data  = r_ifu_rd_data;
  assign exec_rd_data = r_exec_rd_data;
  assign exec_rd_cnt  = r_exec_rd_cnt;
  assign exec_wr_cnt  = r_exec_wr_cnt;
  assign ifu_rd_cnt   = r_ifu_rd_cnt;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_pdp_exec_mem_responder.sv
// tb/tb_pdp_exec_mem_responder.sv - directed table-driven bench for pdp_exec_mem_responder
module tb_pdp_exec_mem_responder;

  localparam int AW = 13;
  localparam int DW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ifu_rd_req;
  logic [AW-1:0] ifu_rd_addr;
  logic [DW-1:0] ifu_rd_data;
  logic          exec_rd_req;
  logic [AW-1:0] exec_rd_addr;
  logic [DW-1:0] exec_rd_data;
  logic          exec_wr_req;
  logic [AW-1:0] exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic          init_wr_en;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;
  logic [CW-1:0] exec_rd_cnt;
  logic [CW-1:0] exec_wr_cnt;
  logic [CW-1:0] ifu_rd_cnt;
  logic          proto_err;

  int checks = 0;
  int failures = 0;

  pdp_exec_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4096), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .init_wr_en(init_wr_en), .init_addr(init_addr), .init_data(init_data),
    .exec_rd_cnt(exec_rd_cnt), .exec_wr_cnt(exec_wr_cnt), .ifu_rd_cnt(ifu_rd_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          ir;
    logic [AW-1:0] ia;
    logic          er;
    logic [AW-1:0] ea;
    logic          ew;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] iaa;
    logic [DW-1:0] id;
    logic [DW-1:0] x_ifu;
    logic [DW-1:0] x_exec;
    logic [CW-1:0] x_rdc;
    logic [CW-1:0] x_wrc;
    logic [CW-1:0] x_ifc;
    logic          x_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst_n, input logic ir, input logic [AW-1:0] ia,
    input logic er, input logic [AW-1:0] ea,
    input logic ew, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
    input logic ie, input logic [AW-1:0] iaa, input logic [DW-1:0] id,
    input logic [DW-1:0] x_ifu, input logic [DW-1:0] x_exec,
    input logic [CW-1:0] x_rdc, input logic [CW-1:0] x_wrc, input logic [CW-1:0] x_ifc,
    input logic x_err);
    vec_t v;
    v.rst_n = rst_n; v.ir = ir; v.ia = ia; v.er = er; v.ea = ea;
    v.ew = ew; v.wa = wa; v.wd = wd; v.ie = ie; v.iaa = iaa; v.id = id;
    v.x_ifu = x_ifu; v.x_exec = x_exec; v.x_rdc = x_rdc; v.x_wrc = x_wrc;
    v.x_ifc = x_ifc; v.x_err = x_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_n      = v.rst_n;
    ifu_rd_req   = v.ir;  ifu_rd_addr  = v.ia;
    exec_rd_req  = v.er;  exec_rd_addr = v.ea;
    exec_wr_req  = v.ew;  exec_wr_addr = v.wa; exec_wr_data = v.wd;
    init_wr_en   = v.ie;  init_addr    = v.iaa; init_data   = v.id;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    drive(mk(1, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
  endtask

  initial begin
    // rst ir ia  er ea  ew wa wd  ie iaa id | ifu exec rdc wrc ifc err
    vecs.push_back(mk(0, 0,0,       0,0,       0,0,0,           0,0,0,           'h000,'h000,0,0,0,0)); // reset
    vecs.push_back(mk(1, 0,0,       0,0,       0,0,0,           1,'h010,'h123,   'h000,'h000,0,0,0,0));
    vecs.push_back(mk(1, 0,0,       0,0,       0,0,0,           1,'h030,'hFFF,   'h000,'h000,0,0,0,0));
    vecs.push_back(mk(1, 0,0,       0,0,       0,0,0,           1,'h050,'h0AA,   'h000,'h000,0,0,0,0));
    vecs.push_back(mk(1, 0,0,       1,'h010,   0,0,0,           0,0,0,           'h000,'h123,1,0,0,0)); // basic read
    vecs.push_back(mk(1, 0,0,       0,0,       0,0,0,           0,0,0,           'h000,'h123,1,0,0,0)); // hold
    vecs.push_back(mk(1, 1,'h020,   0,0,       1,'h020,'hABC,   0,0,0,           'hABC,'h123,1,1,1,0)); // write-first to fetch
    vecs.push_back(mk(1, 0,0,       1,'h030,   0,0,0,           0,0,0,           'hABC,'hFFF,2,1,1,0)); // ISZ read
    vecs.push_back(mk(1, 0,0,       0,0,       1,'h030,'h000,   0,0,0,           'hABC,'hFFF,2,2,1,0)); // ISZ write
    vecs.push_back(mk(1, 0,0,       1,'h030,   0,0,0,           0,0,0,           'hABC,'h000,3,2,1,0));
    vecs.push_back(mk(1, 0,0,       1,'h1010,  0,0,0,           0,0,0,           'hABC,'h123,4,2,1,0)); // upper bit ignored
    vecs.push_back(mk(1, 1,'h1030,  0,0,       0,0,0,           0,0,0,           'h000,'h123,4,2,2,0));
    vecs.push_back(mk(1, 1,'h040,   0,0,       1,'h040,'h222,   1,'h040,'h111,   'h111,'h123,4,2,3,1)); // init wins
    vecs.push_back(mk(1, 1,'h040,   0,0,       0,0,0,           0,0,0,           'h111,'h123,4,2,4,1));
    vecs.push_back(mk(1, 0,0,       1,'h010,   0,0,0,           0,0,0,           'h111,'h123,5,2,4,1));
    vecs.push_back(mk(0, 1,'h010,   1,'h010,   1,'h050,'h555,   0,0,0,           'h000,'h000,0,0,0,0)); // reset mid-read
    vecs.push_back(mk(1, 0,0,       1,'h050,   0,0,0,           0,0,0,           'h000,'h0AA,1,0,0,0)); // array survived
    vecs.push_back(mk(1, 0,0,       1,'h060,   1,'h060,'h321,   0,0,0,           'h000,'h321,2,1,0,1)); // rd+wr together
    vecs.push_back(mk(0, 0,0,       0,0,       0,0,0,           0,0,0,           'h000,'h000,0,0,0,0));
    vecs.push_back(mk(1, 0,0,       1,'h010,   0,0,0,           0,0,0,           'h000,'h123,1,0,0,0));
    vecs.push_back(mk(1, 0,0,       1,'h010,   0,0,0,           0,0,0,           'h000,'h123,2,0,0,0));
    vecs.push_back(mk(1, 0,0,       1,'h010,   0,0,0,           0,0,0,           'h000,'h123,3,0,0,1)); // 3rd held read
    vecs.push_back(mk(1, 0,0,       0,0,       0,0,0,           0,0,0,           'h000,'h123,3,0,0,1)); // sticky

    drive(mk(0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ifu_rd_data", i), ifu_rd_data, vecs[i].x_ifu);
      chk($sformatf("v%0d_exec_rd_data", i), exec_rd_data, vecs[i].x_exec);
      chk($sformatf("v%0d_exec_rd_cnt", i), DW'(exec_rd_cnt), DW'(vecs[i].x_rdc));
      chk($sformatf("v%0d_exec_wr_cnt", i), DW'(exec_wr_cnt), DW'(vecs[i].x_wrc));
      chk($sformatf("v%0d_ifu_rd_cnt", i), DW'(ifu_rd_cnt), DW'(vecs[i].x_ifc));
      chk($sformatf("v%0d_proto_err", i), DW'(proto_err), DW'(vecs[i].x_err));
    end

    // Counter saturation: 20 fetch reads into a 4-bit counter must stop at 15.
    drive(mk(0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive(mk(1, 1,'h060, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
      @(posedge clk); #1;
    end
    chk("ifu_cnt_saturate", DW'(ifu_rd_cnt), DW'(15));
    chk("ifu_sat_data", ifu_rd_data, 12'h321);

    // Write counter saturation with distinct data each write; last write must be the stored word.
    for (int i = 0; i < 18; i++) begin
      drive(mk(1, 0,0, 0,0, 1,'h070,DW'(12'h700 + i), 0,0,0, 0,0,0,0,0,0));
      @(posedge clk); #1;
    end
    chk("exec_wr_cnt_saturate", DW'(exec_wr_cnt), DW'(15));
    chk("wr_sat_no_err", DW'(proto_err), DW'(0));
    drive(mk(1, 0,0, 1,'h070, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("wr_sat_readback", exec_rd_data, 12'h711);
    chk("wr_sat_rd_cnt", DW'(exec_rd_cnt), DW'(1));
    idle_cycle();
    chk("hold_after_idle", exec_rd_data, 12'h711);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
